// File: rtl/line_memory_pkg.sv
// Shared types and constants for the line_memory responder.
package line_memory_pkg;

  localparam int LINE_BITS   = 256;
  localparam int LINE_BYTES  = 32;
  localparam int OFFSET_BITS = 5;
  localparam int ADDR_BITS   = 32;
  localparam int LINE_IDX_W  = ADDR_BITS - OFFSET_BITS;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Full line number of a byte address (offset bits dropped).
  function automatic logic [LINE_IDX_W-1:0] line_index(input logic [ADDR_BITS-1:0] addr);
    return addr[ADDR_BITS-1:OFFSET_BITS];
  endfunction

endpackage

// File: rtl/line_memory_if.sv
// Cache-to-memory line interface. mem_err_o exists only when
// LINE_MEMORY_RANGE_CHECK_EN is defined.
interface line_memory_if;
  import line_memory_pkg::*;

  logic                  mem_enable_i;
  logic                  mem_write_i;
  logic [ADDR_BITS-1:0]  mem_addr_i;
  logic [LINE_BITS-1:0]  mem_data_i;
  logic [LINE_BITS-1:0]  mem_data_o;
  logic                  mem_ack_o;
`ifdef LINE_MEMORY_RANGE_CHECK_EN
  logic                  mem_err_o;

  modport master (output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
                  input  mem_data_o, mem_ack_o, mem_err_o);
  modport slave  (input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
                  output mem_data_o, mem_ack_o, mem_err_o);
`else
  modport master (output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
                  input  mem_data_o, mem_ack_o);
  modport slave  (input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
                  output mem_data_o, mem_ack_o);
`endif

endinterface

// File: rtl/line_memory_array.sv
// DEPTH x 256-bit line storage: synchronous write, registered read.
// Contents are never reset; the bench preloads mem_q hierarchically.
module line_memory_array
  import line_memory_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic                 clr_i,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic [LINE_BITS-1:0] wdata_i,
  output logic [LINE_BITS-1:0] rdata_o
);

  logic [LINE_BITS-1:0] mem_q [DEPTH];
  logic [LINE_BITS-1:0] rdata_d;
  logic [LINE_BITS-1:0] rdata_q;

  // Line write port; storage itself has no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Read data register: load on read, zero line for a rejected read, else hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      if (clr_i) begin
        rdata_d = {LINE_BITS{1'b0}};
      end else begin
        rdata_d = mem_q[idx_i];
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data flop, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= {LINE_BITS{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory.sv
// Off-chip line memory model responding to the data cache memory port.
// One request at a time, fixed LATENCY, one-cycle ack.
// Optional feature macro: LINE_MEMORY_RANGE_CHECK_EN (out-of-range index
// flagged on mem_err_o instead of wrapping modulo DEPTH).
module line_memory
  import line_memory_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  line_memory_if.slave  mem
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e               state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic                 wr_d, wr_q;
  logic [IDX_W-1:0]     idx_d, idx_q;
  logic [LINE_BITS-1:0] data_d, data_q;
  logic                 ack_d, ack_q;
  logic                 oor_d, oor_q;

  logic [LINE_IDX_W-1:0] req_line_s;
  logic [IDX_W-1:0]      req_idx_s;
  logic                  req_oor_s;
  logic                  commit_s;
  logic                  commit_wr_s;
  logic [IDX_W-1:0]      commit_idx_s;
  logic [LINE_BITS-1:0]  commit_data_s;
  logic                  commit_oor_s;
  logic                  unused_s;

  assign req_line_s = line_index(mem.mem_addr_i);
  assign req_idx_s  = req_line_s[IDX_W-1:0];
`ifdef LINE_MEMORY_RANGE_CHECK_EN
  assign req_oor_s  = (req_line_s >= LINE_IDX_W'(DEPTH));
`else
  assign req_oor_s  = 1'b0;
`endif
  assign unused_s   = ^{mem.mem_addr_i[OFFSET_BITS-1:0], req_line_s};

  // Next state, request capture and the commit strobe for the edge entering ACK.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    idx_d         = idx_q;
    data_d        = data_q;
    oor_d         = oor_q;
    commit_s      = 1'b0;
    commit_wr_s   = wr_q;
    commit_idx_s  = idx_q;
    commit_data_s = data_q;
    commit_oor_s  = oor_q;
    case (state_q)
      IDLE: begin
        if (mem.mem_enable_i) begin
          wr_d   = mem.mem_write_i;
          idx_d  = req_idx_s;
          data_d = mem.mem_data_i;
          oor_d  = req_oor_s;
          cnt_d  = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            // No BUSY phase: commit straight from the request inputs.
            state_d       = ACK;
            commit_s      = 1'b1;
            commit_wr_s   = mem.mem_write_i;
            commit_idx_s  = req_idx_s;
            commit_data_s = mem.mem_data_i;
            commit_oor_s  = req_oor_s;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d  = ACK;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACK: begin
        // Enable is still held by the initiator here; it is not a new request.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ack_d = commit_s;
  end

  // Control and capture registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      wr_q    <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      data_q  <= {LINE_BITS{1'b0}};
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oor_q   <= oor_d;
      ack_q   <= ack_d;
    end
  end

  line_memory_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (commit_s & commit_wr_s & ~commit_oor_s),
    .re_i    (commit_s & ~commit_wr_s),
    .clr_i   (commit_oor_s),
    .idx_i   (commit_idx_s),
    .wdata_i (commit_data_s),
    .rdata_o (mem.mem_data_o)
  );

  assign mem.mem_ack_o = ack_q;

`ifdef LINE_MEMORY_RANGE_CHECK_EN
  logic err_d, err_q;

  assign err_d = commit_s & commit_oor_s;

  // Error flag pulses together with the ack of an out-of-range request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign mem.mem_err_o = err_q;
`endif

endmodule

// File: tb/tb_line_memory.sv
// Scoreboard bench for line_memory: expected ack cycle, read line and error
// flag are queued when a request is driven and compared at each ack.
module tb_line_memory;
  import line_memory_pkg::*;

  localparam int DEPTH = 512;
  localparam int LAT   = 10;

  typedef struct {
    int                   ack_cyc;
    logic [LINE_BITS-1:0] data;
    logic                 err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  line_memory_if mem_if ();

  line_memory #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .mem   (mem_if)
  );

  always #5 clk = ~clk;

  exp_t                 sb_q[$];
  logic [LINE_BITS-1:0] model [DEPTH];
  logic [LINE_BITS-1:0] last_rd = {LINE_BITS{1'b0}};
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [LINE_BITS-1:0] obs,
                       input logic [LINE_BITS-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare each ack against the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mem_if.mem_ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_ack", 256'd1, 256'd0);
      end else begin
        e = sb_q.pop_front();
        check("ack_cycle", LINE_BITS'(cyc), LINE_BITS'(e.ack_cyc));
        check("ack_data", mem_if.mem_data_o, e.data);
`ifdef LINE_MEMORY_RANGE_CHECK_EN
        check("ack_err", LINE_BITS'(mem_if.mem_err_o), LINE_BITS'(e.err));
`endif
      end
    end
  end

  // Drive a request (call at a negedge with the DUT idle) and queue its result.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [LINE_BITS-1:0] data);
    exp_t e;
    int   idx;
    logic oor;
    idx = int'(addr[31:5]);
    oor = 1'b0;
`ifdef LINE_MEMORY_RANGE_CHECK_EN
    oor = (idx >= DEPTH);
`endif
    e.ack_cyc = cyc + 1 + LAT;
    e.err     = oor;
    if (wr) begin
      if (!oor) model[idx % DEPTH] = data;
    end else begin
      last_rd = oor ? {LINE_BITS{1'b0}} : model[idx % DEPTH];
    end
    e.data = last_rd;
    sb_q.push_back(e);
    mem_if.mem_enable_i = 1'b1;
    mem_if.mem_write_i  = wr;
    mem_if.mem_addr_i   = addr;
    mem_if.mem_data_i   = data;
  endtask

  // After the accept edge, garble the request fields (enable stays high).
  task automatic scramble();
    @(posedge clk);
    #1;
    mem_if.mem_write_i = 1'($urandom);
    mem_if.mem_addr_i  = $urandom;
    mem_if.mem_data_i  = {8{$urandom}};
  endtask

  // Wait, bounded, until a negedge sees ack high.
  task automatic wait_ack();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = (mem_if.mem_ack_o === 1'b1);
    end
    if (!seen) check("ack_timeout", 256'd0, 256'd1);
  endtask

  // Full transaction with enable held through the ack cycle.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [LINE_BITS-1:0] data);
    @(negedge clk);
    issue(wr, addr, data);
    scramble();
    wait_ack();
    @(posedge clk);
    #1;
    mem_if.mem_enable_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [LINE_BITS-1:0] d;
    logic [LINE_BITS-1:0] saved;
    logic [31:0]          a;

    mem_if.mem_enable_i = 1'b0;
    mem_if.mem_write_i  = 1'b0;
    mem_if.mem_addr_i   = 32'h0000_0000;
    mem_if.mem_data_i   = {LINE_BITS{1'b0}};

    model[0] = {32{8'h3C}};
    model[4] = {32{8'hA5}};
    model[7] = {32{8'h77}};
    dut.u_array.mem_q[0] = model[0];
    dut.u_array.mem_q[4] = model[4];
    dut.u_array.mem_q[7] = model[7];

    // Reset held 3 cycles with a read request pending on the bus.
    #1 rst_n = 1'b0;
    mem_if.mem_enable_i = 1'b1;
    mem_if.mem_addr_i   = 32'h0000_0080;
    repeat (3) begin
      @(negedge clk);
      check("rst_ack", LINE_BITS'(mem_if.mem_ack_o), 256'd0);
      check("rst_data", mem_if.mem_data_o, {LINE_BITS{1'b0}});
    end
    mem_if.mem_enable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Preloaded read.
    do_req(1'b0, 32'h0000_0080, {LINE_BITS{1'b0}});

    // Write then read back the same line.
    do_req(1'b1, 32'h0000_0100, {16{16'h1234}});
    do_req(1'b0, 32'h0000_0100, {LINE_BITS{1'b0}});

    // Enable kept high across ACK: next request lands after one IDLE cycle.
    @(negedge clk);
    issue(1'b1, 32'h0000_0200, {8{32'hDEAD_BEEF}});
    scramble();
    wait_ack();
    @(negedge clk);
    issue(1'b0, 32'h0000_0200, {LINE_BITS{1'b0}});
    scramble();
    wait_ack();
    @(posedge clk);
    #1 mem_if.mem_enable_i = 1'b0;

    // Reset in the middle of a write to line 7: write must be lost.
    saved = model[7];
    @(negedge clk);
    issue(1'b1, 32'h0000_00E0, {4{64'h0BAD_F00D_CAFE_0001}});
    void'(sb_q.pop_back());
    model[7] = saved;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    mem_if.mem_enable_i = 1'b0;
    last_rd = {LINE_BITS{1'b0}};
    @(negedge clk);
    check("midrst_ack", LINE_BITS'(mem_if.mem_ack_o), 256'd0);
    check("midrst_data", mem_if.mem_data_o, {LINE_BITS{1'b0}});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_req(1'b0, 32'h0000_00E0, {LINE_BITS{1'b0}});

    // Index 512: wraps onto line 0, or is rejected with the range check.
    do_req(1'b1, 32'h0000_4000, {8{32'h5A5A_0F0F}});
    do_req(1'b0, 32'h0000_0000, {LINE_BITS{1'b0}});

    // A few random in-range lines, offset bits set to non-zero garbage.
    for (int i = 0; i < 4; i++) begin
      a = {18'd0, 9'($urandom_range(DEPTH - 1)), 5'($urandom)};
      d = {8{$urandom}};
      do_req(1'b1, a, d);
      do_req(1'b0, a ^ 32'h0000_001F, {LINE_BITS{1'b0}});
    end

    repeat (20) @(negedge clk);
    check("sb_empty", LINE_BITS'(sb_q.size()), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
